// File: rtl/ewb_pkg.sv
// Shared types for the eviction write buffer controller.
package ewb_pkg;

  typedef enum logic [1:0] {
    EWB_IDLE  = 2'd0,
    EWB_READ  = 2'd1,
    EWB_DRAIN = 2'd2
  } ewb_state_t;

endpackage

// File: rtl/ewb_idle_timer.sv
// Saturating idle counter; expire is high while the count sits at LIMIT.
module ewb_idle_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != LIMIT_C)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = (count_reg == LIMIT_C);

endmodule

// File: rtl/ewb_control.sv
// Eviction write buffer controller: accepts evictions locally, passes reads
// through, and drains the buffered line on conflict, hazard or idle timeout.
module ewb_control
  import ewb_pkg::*;
#(
  parameter int unsigned IDLE_DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp,
  input  logic match,
  output logic addr_load,
  output logic data_load,
  output logic writing,
  output logic wb_valid
);

  ewb_state_t state_reg, state_next;
  logic       valid_reg, valid_next;
  logic       expire, timer_inc;
  logic       mem_resp_c, pmem_read_c, pmem_write_c;
  logic       addr_load_c, data_load_c, writing_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EWB_IDLE;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
    end
  end

  // Count only quiet idle cycles with a line held; anything else restarts the interval.
  assign timer_inc = (state_reg == EWB_IDLE) && !mem_read && !mem_write && valid_reg && !expire;

  ewb_idle_timer #(
    .LIMIT(IDLE_DRAIN_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!timer_inc),
    .inc    (timer_inc),
    .expire (expire)
  );

  always_comb begin
    state_next   = state_reg;
    valid_next   = valid_reg;
    mem_resp_c   = 1'b0;
    pmem_read_c  = 1'b0;
    pmem_write_c = 1'b0;
    addr_load_c  = 1'b0;
    data_load_c  = 1'b0;
    writing_c    = 1'b0;
    unique case (state_reg)
      EWB_IDLE: begin
        if (mem_read) begin
          // A read of the buffered address must see the line in pmem first.
          state_next = (valid_reg && match) ? EWB_DRAIN : EWB_READ;
        end else if (mem_write) begin
          if (!valid_reg) begin
            addr_load_c = 1'b1;
            data_load_c = 1'b1;
            mem_resp_c  = 1'b1;
            valid_next  = 1'b1;
          end else if (match) begin
            data_load_c = 1'b1;
            mem_resp_c  = 1'b1;
          end else begin
            state_next = EWB_DRAIN;
          end
        end else if (valid_reg && expire) begin
          state_next = EWB_DRAIN;
        end
      end
      EWB_READ: begin
        pmem_read_c = 1'b1;
        if (pmem_resp) begin
          mem_resp_c = 1'b1;
          state_next = EWB_IDLE;
        end
      end
      EWB_DRAIN: begin
        pmem_write_c = 1'b1;
        writing_c    = 1'b1;
        if (pmem_resp) begin
          valid_next = 1'b0;
          state_next = EWB_IDLE;
        end
      end
      default: state_next = EWB_IDLE;
    endcase
  end

  // Gate with reset so a request held during reset cannot leak through the Mealy paths.
  assign mem_resp   = rst & mem_resp_c;
  assign pmem_read  = rst & pmem_read_c;
  assign pmem_write = rst & pmem_write_c;
  assign addr_load  = rst & addr_load_c;
  assign data_load  = rst & data_load_c;
  assign writing    = rst & writing_c;
  assign wb_valid   = valid_reg;

endmodule
